// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter (WB stage vs long-latency unit) with pending-write scoreboard and ID stalls.
// Latency: write port registered, 1 cycle; stall and ll_ready combinational.
// Backpressure: WB wins the port; an LL result starved for STARVE_LIMIT cycles freezes WB for one cycle.
module regfile_wb_scheduler #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_dest,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    output logic        stall,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_register,
    input  logic [31:0] wb_write_data,
    output logic        wb_hold,
    input  logic        ll_valid,
    input  logic [4:0]  ll_dest,
    input  logic [31:0] ll_data,
    output logic        ll_ready,
    output logic        rf_reg_write,
    output logic [4:0]  rf_write_register,
    output logic [31:0] rf_write_data,
    output logic [31:0] pending
);
    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

    localparam logic [3:0] MAX_CNT    = 4'(MAX_OUTSTANDING);
    localparam logic [3:0] WAIT_LAST  = 4'(STARVE_LIMIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  out_cnt_q, out_cnt_d;
    logic [31:0] pending_q, pending_d;
    logic        rf_reg_write_q, rf_reg_write_d;
    logic [4:0]  rf_write_register_q, rf_write_register_d;
    logic [31:0] rf_write_data_q, rf_write_data_d;

    logic wb_req, force_st, ll_fire, issue_go;
    logic [3:0] cnt_inc;

    always_comb begin
        wb_req   = wb_reg_write & (wb_write_register != 5'd0);
        force_st = (state_q == FORCE);
        ll_ready = force_st | ~wb_req;
        ll_fire  = ll_valid & ll_ready;
        wb_hold  = force_st;

        stall = (id_rs_used & (id_rs != 5'd0) & pending_q[id_rs])
              | (id_rt_used & (id_rt != 5'd0) & pending_q[id_rt])
              | (issue_valid & pending_q[issue_dest])
              | (issue_valid & (out_cnt_q == MAX_CNT));
        issue_go = issue_valid & ~stall;

        // Clear first, then set: a fire can never target a register issued this cycle.
        pending_d = pending_q;
        if (ll_fire)
            pending_d[ll_dest] = 1'b0;
        if (issue_go && issue_dest != 5'd0)
            pending_d[issue_dest] = 1'b1;

        cnt_inc = out_cnt_q + {3'd0, issue_go};
        if (ll_fire && cnt_inc != 4'd0)
            cnt_inc = cnt_inc - 4'd1;
        out_cnt_d = cnt_inc;

        rf_reg_write_d      = 1'b0;
        rf_write_register_d = rf_write_register_q;
        rf_write_data_d     = rf_write_data_q;
        if (wb_req && !force_st) begin
            rf_reg_write_d      = 1'b1;
            rf_write_register_d = wb_write_register;
            rf_write_data_d     = wb_write_data;
        end else if (ll_fire) begin
            rf_reg_write_d      = (ll_dest != 5'd0);
            rf_write_register_d = ll_dest;
            rf_write_data_d     = ll_data;
        end

        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (ll_valid && !ll_ready) begin
                    state_d    = WAIT;
                    wait_cnt_d = 4'd1;
                end
            end
            WAIT: begin
                if (ll_fire) begin
                    state_d    = IDLE;
                    wait_cnt_d = 4'd0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = FORCE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            FORCE: begin
                state_d    = IDLE;
                wait_cnt_d = 4'd0;
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q             <= IDLE;
            wait_cnt_q          <= 4'd0;
            out_cnt_q           <= 4'd0;
            pending_q           <= 32'd0;
            rf_reg_write_q      <= 1'b0;
            rf_write_register_q <= 5'd0;
            rf_write_data_q     <= 32'd0;
        end else begin
            state_q             <= state_d;
            wait_cnt_q          <= wait_cnt_d;
            out_cnt_q           <= out_cnt_d;
            pending_q           <= pending_d;
            rf_reg_write_q      <= rf_reg_write_d;
            rf_write_register_q <= rf_write_register_d;
            rf_write_data_q     <= rf_write_data_d;
        end
    end

    assign rf_reg_write      = rf_reg_write_q;
    assign rf_write_register = rf_write_register_q;
    assign rf_write_data     = rf_write_data_q;
    assign pending           = pending_q;
endmodule
